// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle around the fetch queue.
//   imem_req_*  : fetch requests to instruction memory (valid/ready, addr)
//   imem_rsp_*  : in-order instruction responses (valid, data; no backpressure)
//   redirect_*  : branch redirect (flush and refetch at redirect_pc)
//   inst_*      : instruction stream to decode (valid/ready, data, pc)
//   fq_count    : registered queue occupancy
// Modports: master = fetch_queue side, slave = memory/decode/branch side.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [63:0]   imem_req_addr;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          redirect_valid;
    logic [63:0]   redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst_data;
    logic [63:0]   inst_pc;
    logic [CW-1:0] fq_count;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, fq_count,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, fq_count,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch/prefetch stage.
// Issues word-aligned fetches, tags returned instructions with their PC and
// buffers them in a DEPTH-entry FIFO toward decode. Requests are credit
// limited (outstanding + occupancy < DEPTH) so the FIFO cannot overflow.
// A redirect flushes the FIFO and enters DRAIN until all stale in-flight
// responses have been discarded.
// Ports:
//   Clk, reset : clock, synchronous active-high reset
//   bus        : fetch_queue_if.master (imem req/rsp, redirect, inst, fq_count)
// Parameters: DEPTH (power of two, >= 2), RESET_PC.
// Optional: FETCH_QUEUE_BYPASS_EN -- when the FIFO is empty a live response is
// also presented to decode in the same cycle (and not stored if consumed).
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic          Clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [63:0]     fetch_pc, rsp_pc;
    logic [CW-1:0]   outstanding, drop_cnt, count;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [31:0]     mem_data [DEPTH];
    logic [63:0]     mem_pc   [DEPTH];

    logic            req_valid, req_fire, rsp_ok, head_valid, bypass_hit;
    logic            push, pop, credit_ok;
    logic [CW:0]     occ;
    logic [CW-1:0]   drop_new;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok     = bus.imem_rsp_valid && (outstanding != '0);
    assign occ        = {1'b0, outstanding} + {1'b0, count};
    assign credit_ok  = occ < (CW+1)'(DEPTH);
    assign req_fire   = req_valid && bus.imem_req_ready;
    assign head_valid = (count != '0);
    // Stale requests still in flight, including any handshake/response this cycle.
    assign drop_new   = outstanding + CW'(req_fire) - CW'(rsp_ok);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_hit    = (state == FETCH) && !bus.redirect_valid && rsp_ok && !head_valid;
    assign bus.inst_data = head_valid ? mem_data[rd_ptr] : (bypass_hit ? bus.imem_rsp_data : 32'h0);
    assign bus.inst_pc   = head_valid ? mem_pc[rd_ptr]   : (bypass_hit ? rsp_pc : RESET_PC);
`else
    assign bypass_hit    = 1'b0;
    assign bus.inst_data = head_valid ? mem_data[rd_ptr] : 32'h0;
    assign bus.inst_pc   = head_valid ? mem_pc[rd_ptr]   : RESET_PC;
`endif

    assign bus.inst_valid     = head_valid || bypass_hit;
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.fq_count       = count;

    assign pop  = head_valid && bus.inst_ready;
    // A bypassed instruction taken by decode in the same cycle is never stored.
    assign push = (state == FETCH) && !bus.redirect_valid && rsp_ok &&
                  !(bypass_hit && bus.inst_ready);

    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        case (state)
            FETCH: req_valid = !reset && !bus.redirect_valid && credit_ok;
            DRAIN: if (rsp_ok && drop_cnt == CW'(1)) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
        if (bus.redirect_valid)
            state_nxt = (drop_new != '0) ? DRAIN : FETCH;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            state <= state_nxt;
            if (bus.redirect_valid) begin
                fetch_pc    <= bus.redirect_pc;
                rsp_pc      <= bus.redirect_pc;
                outstanding <= drop_new;
                drop_cnt    <= drop_new;
                count       <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 64'd4;
                // Dropped responses in DRAIN do not advance the response PC.
                if (rsp_ok && state == FETCH)
                    rsp_pc <= rsp_pc + 64'd4;
                if (rsp_ok && state == DRAIN)
                    drop_cnt <= drop_cnt - CW'(1);
                outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push && !reset) begin
            mem_data[wr_ptr] <= bus.imem_rsp_data;
            mem_pc[wr_ptr]   <= rsp_pc;
        end
    end
endmodule
